// File: rtl/conv3_relu_pipe_if.sv
// rtl/conv3_relu_pipe_if.sv - window input, weight load and pixel output bundle for conv3_relu_pipe
interface conv3_relu_pipe_if #(
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 8,
   parameter int OUT_W    = 8
);
   logic                       start;
   logic                       weight_load;
   logic signed [WEIGHT_W-1:0] w0_in;
   logic signed [WEIGHT_W-1:0] w1_in;
   logic signed [WEIGHT_W-1:0] w2_in;
   logic                       in_valid;
   logic signed [DATA_W-1:0]   rd_data1;
   logic signed [DATA_W-1:0]   rd_data2;
   logic signed [DATA_W-1:0]   rd_data3;
   logic                       out_valid;
   logic [OUT_W-1:0]           out_data;
   logic [3:0]                 out_idx;
   logic                       busy;
   logic                       done;
   logic                       err;

   modport master (
      output start, weight_load, w0_in, w1_in, w2_in,
      output in_valid, rd_data1, rd_data2, rd_data3,
      input  out_valid, out_data, out_idx, busy, done, err
   );

   modport slave (
      input  start, weight_load, w0_in, w1_in, w2_in,
      input  in_valid, rd_data1, rd_data2, rd_data3,
      output out_valid, out_data, out_idx, busy, done, err
   );
endinterface

// File: rtl/conv3_relu_pipe.sv
// rtl/conv3_relu_pipe.sv - 3-tap signed convolution with ReLU/saturation, one pixel per window
module conv3_relu_pipe #(
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 8,
   parameter int OUT_W    = 8,
   parameter int NUM_OUT  = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   conv3_relu_pipe_if.slave     bus
);
   localparam int PROD_W = DATA_W + WEIGHT_W;
   localparam int SUM_W  = PROD_W + 2;
   localparam logic [3:0] LAST_IDX = 4'(NUM_OUT - 1);
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2**OUT_W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;

   stateType                   state, nextState;
   logic [3:0]                 acceptCnt;
   logic signed [WEIGHT_W-1:0] w0, w1, w2;
   logic                       v1, v2;
   logic signed [PROD_W-1:0]   p0, p1, p2;
   logic signed [SUM_W-1:0]    sum;
   logic                       outValid;
   logic [OUT_W-1:0]           outData;
   logic [OUT_W-1:0]           satVal;
   logic [3:0]                 outIdx;
   logic                       errReg;
   logic                       startTaken, accept, dropped, lastOut;

   always_comb begin
      startTaken = bus.start && (state != RUN);
      accept     = bus.in_valid && (state == RUN) && (acceptCnt < 4'(NUM_OUT));
      dropped    = bus.in_valid && !accept;
      lastOut    = outValid && (outIdx == LAST_IDX) && (state == RUN);
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: if (bus.start) nextState = RUN;
         RUN:        if (lastOut)   nextState = DONE;
         default:    nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // A window sampled alongside weight_load still multiplies by the old registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w0 <= '0;
         w1 <= '0;
         w2 <= '0;
      end else if (bus.weight_load) begin
         w0 <= bus.w0_in;
         w1 <= bus.w1_in;
         w2 <= bus.w2_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acceptCnt <= '0;
         outIdx    <= '0;
         errReg    <= 1'b0;
      end else begin
         if (startTaken)  acceptCnt <= '0;
         else if (accept) acceptCnt <= acceptCnt + 4'd1;
         if (startTaken)    outIdx <= '0;
         else if (outValid) outIdx <= outIdx + 4'd1;
         errReg <= (startTaken ? 1'b0 : errReg) | dropped;
      end
   end

   always_comb begin
      satVal = sum[OUT_W-1:0];
      if (sum[SUM_W-1])       satVal = '0;
      else if (sum > SAT_MAX) satVal = '1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1       <= 1'b0;
         v2       <= 1'b0;
         outValid <= 1'b0;
         p0       <= '0;
         p1       <= '0;
         p2       <= '0;
         sum      <= '0;
         outData  <= '0;
      end else begin
         v1       <= accept;
         v2       <= v1;
         outValid <= v2;
         p0       <= PROD_W'(bus.rd_data1) * PROD_W'(w0);
         p1       <= PROD_W'(bus.rd_data2) * PROD_W'(w1);
         p2       <= PROD_W'(bus.rd_data3) * PROD_W'(w2);
         sum      <= SUM_W'(p0) + SUM_W'(p1) + SUM_W'(p2);
         if (v2) outData <= satVal;
      end
   end

   assign bus.out_valid = outValid;
   assign bus.out_data  = outData;
   assign bus.out_idx   = outIdx;
   assign bus.busy      = (state == RUN);
   assign bus.done      = lastOut;
   assign bus.err       = errReg;
endmodule

// File: tb/tb_conv3_relu_pipe.sv
// tb/tb_conv3_relu_pipe.sv - directed self-checking bench for conv3_relu_pipe
module tb_conv3_relu_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   strayDone = 0;
   int   obsData[$];
   int   obsIdx[$];
   int   obsDone[$];
   int   obsCyc[$];
   int   firstCyc;

   conv3_relu_pipe_if bus ();

   conv3_relu_pipe dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
         obsData.push_back(int'(bus.out_data));
         obsIdx.push_back(int'(bus.out_idx));
         obsDone.push_back(int'(bus.done));
         obsCyc.push_back(cyc);
      end
      if (!rst && bus.done && !bus.out_valid) strayDone++;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   task automatic checkVal(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearObs();
      obsData.delete();
      obsIdx.delete();
      obsDone.delete();
      obsCyc.delete();
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clearObs();
   endtask

   task automatic loadW(input int a, input int b, input int c);
      bus.weight_load = 1'b1;
      bus.w0_in = 8'(a);
      bus.w1_in = 8'(b);
      bus.w2_in = 8'(c);
      tick();
      bus.weight_load = 1'b0;
   endtask

   task automatic startPass();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic setWin(input int a, input int b, input int c);
      bus.in_valid = 1'b1;
      bus.rd_data1 = 8'(a);
      bus.rd_data2 = 8'(b);
      bus.rd_data3 = 8'(c);
   endtask

   task automatic sendWin(input int a, input int b, input int c);
      setWin(a, b, c);
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int rw[3][3];
      int rd[3][3];
      int rexp[3];
      int e;

      bus.start = 1'b0;
      bus.weight_load = 1'b0;
      bus.w0_in = '0;
      bus.w1_in = '0;
      bus.w2_in = '0;
      bus.in_valid = 1'b0;
      bus.rd_data1 = '0;
      bus.rd_data2 = '0;
      bus.rd_data3 = '0;

      tick();
      tick();
      checkVal("rst_out_valid", int'(bus.out_valid), 0);
      checkVal("rst_out_data", int'(bus.out_data), 0);
      checkVal("rst_out_idx", int'(bus.out_idx), 0);
      checkVal("rst_busy", int'(bus.busy), 0);
      checkVal("rst_done", int'(bus.done), 0);
      checkVal("rst_err", int'(bus.err), 0);
      rst = 1'b0;
      clearObs();

      // in_valid while idle
      sendWin(1, 1, 1);
      checkVal("idle_err", int'(bus.err), 1);

      // basic pass, weights (1,2,1)
      loadW(1, 2, 1);
      startPass();
      checkVal("start_busy", int'(bus.busy), 1);
      checkVal("start_clr_err", int'(bus.err), 0);
      checkVal("idle_no_out", obsData.size(), 0);
      firstCyc = cyc;
      for (int k = 0; k < 14; k++) begin
         setWin(k, k + 1, k + 2);
         tick();
      end
      setWin(100, 100, 100);
      tick();
      bus.in_valid = 1'b0;
      checkVal("extra_err", int'(bus.err), 1);
      repeat (6) tick();
      checkVal("basic_count", obsData.size(), 14);
      for (int k = 0; k < 14 && k < obsData.size(); k++) begin
         checkVal($sformatf("basic_data%0d", k), obsData[k], 4 * k + 4);
         checkVal($sformatf("basic_idx%0d", k), obsIdx[k], k);
         checkVal($sformatf("basic_done%0d", k), obsDone[k], (k == 13) ? 1 : 0);
         checkVal($sformatf("basic_cyc%0d", k), obsCyc[k], firstCyc + k + 3);
      end
      checkVal("done_busy", int'(bus.busy), 0);
      checkVal("done_hold_data", int'(bus.out_data), 56);
      checkVal("done_err_sticky", int'(bus.err), 1);
      startPass();
      checkVal("restart_idx", int'(bus.out_idx), 0);
      checkVal("restart_err", int'(bus.err), 0);
      checkVal("restart_busy", int'(bus.busy), 1);

      // ReLU and saturation corners
      rw = '{'{-1, -1, -1}, '{127, 127, 127}, '{1, 0, 0}};
      rd = '{'{10, 20, 30}, '{127, 127, 127}, '{-128, 0, 0}};
      rexp = '{0, 255, 0};
      for (int t = 0; t < 3; t++) begin
         doReset();
         loadW(rw[t][0], rw[t][1], rw[t][2]);
         startPass();
         sendWin(rd[t][0], rd[t][1], rd[t][2]);
         repeat (4) tick();
         checkVal($sformatf("sat_count%0d", t), obsData.size(), 1);
         if (obsData.size() > 0) checkVal($sformatf("sat_data%0d", t), obsData[0], rexp[t]);
      end

      // windows on alternate cycles
      doReset();
      loadW(1, 1, 1);
      startPass();
      for (int k = 0; k < 4; k++) begin
         sendWin(10 * (k + 1), 0, 0);
         tick();
      end
      repeat (4) tick();
      checkVal("gap_count", obsData.size(), 4);
      for (int k = 0; k < 4 && k < obsData.size(); k++) begin
         checkVal($sformatf("gap_data%0d", k), obsData[k], 10 * (k + 1));
         checkVal($sformatf("gap_idx%0d", k), obsIdx[k], k);
         if (k > 0) checkVal($sformatf("gap_space%0d", k), obsCyc[k] - obsCyc[k - 1], 2);
      end
      checkVal("gap_idx_after", int'(bus.out_idx), 4);

      // weight change alongside window 5
      doReset();
      loadW(1, 1, 1);
      startPass();
      for (int k = 0; k < 8; k++) begin
         setWin(k, k, k);
         if (k == 5) begin
            bus.weight_load = 1'b1;
            bus.w0_in = 8'sd2;
            bus.w1_in = 8'sd2;
            bus.w2_in = 8'sd2;
         end
         tick();
         bus.weight_load = 1'b0;
      end
      bus.in_valid = 1'b0;
      repeat (5) tick();
      checkVal("wchg_count", obsData.size(), 8);
      for (int k = 0; k < 8 && k < obsData.size(); k++) begin
         e = (k <= 5) ? 3 * k : 6 * k;
         checkVal($sformatf("wchg_data%0d", k), obsData[k], e);
      end

      // start and in_valid together in IDLE
      doReset();
      loadW(1, 1, 1);
      bus.start = 1'b1;
      setWin(4, 4, 4);
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      checkVal("simul_busy", int'(bus.busy), 1);
      checkVal("simul_err", int'(bus.err), 1);
      repeat (5) tick();
      checkVal("simul_no_out", obsData.size(), 0);

      // reset with the pipe full
      doReset();
      loadW(1, 1, 1);
      startPass();
      sendWin(1, 1, 1);
      setWin(2, 2, 2);
      tick();
      setWin(3, 3, 3);
      tick();
      bus.in_valid = 1'b0;
      checkVal("full_out_valid", int'(bus.out_valid), 1);
      checkVal("full_out_data", int'(bus.out_data), 3);
      clearObs();
      rst = 1'b1;
      #2;
      checkVal("midrst_out_valid", int'(bus.out_valid), 0);
      checkVal("midrst_out_data", int'(bus.out_data), 0);
      checkVal("midrst_out_idx", int'(bus.out_idx), 0);
      checkVal("midrst_busy", int'(bus.busy), 0);
      tick();
      rst = 1'b0;
      repeat (6) tick();
      checkVal("midrst_no_out", obsData.size(), 0);
      startPass();
      sendWin(5, 5, 5);
      repeat (4) tick();
      checkVal("midrst_w_count", obsData.size(), 1);
      if (obsData.size() > 0) checkVal("midrst_w_zero", obsData[0], 0);

      checkVal("stray_done", strayDone, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
